// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for NUM_DIG seven-segment
// digits that share one external 2-bit SEG7 decoder.
//
// Each digit gets a DRIVE slot of DWELL_CYC cycles followed by a BLANK gap of
// BLANK_CYC cycles with every digit off, which stops ghosting between digits.
// Game logic writes codes through a shadow buffer. The shadow buffer is copied
// into the active buffer only on frame boundaries, so a frame is never torn.
//
// Optional feature macro: SEG7_BLINK_EN
//   When defined, the build adds the iBlinkMask port and a frame counter. While
//   the blink phase is 1, masked digits stay dark in their DRIVE slot.
//
// Load strobe: iLoad is a single-cycle qualifier on iVal. It has no
// back-pressure. Every cycle with iLoad=1 captures iVal, and later captures
// overwrite earlier ones within the same frame.
//
// oDbgState exposes the FSM state (0=IDLE, 1=DRIVE, 2=BLANK) for checkers.

module seg7_scan_ctrl #(
   parameter int NUM_DIG   = 4,
   parameter int DWELL_CYC = 50000,
   parameter int BLANK_CYC = 500
`ifdef SEG7_BLINK_EN
   ,
   parameter int BLINK_FRAMES = 250
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2*NUM_DIG-1:0] iVal,
   input  logic                 iLoad,
   output logic [1:0]           oDIG,
   input  logic [6:0]           iSEG,
   output logic [6:0]           oSEG,
   output logic [NUM_DIG-1:0]   oAN,
   output logic                 oFrameStart,
`ifdef SEG7_BLINK_EN
   input  logic [NUM_DIG-1:0]   iBlinkMask,
`endif
   output logic [1:0]           oDbgState
);

   // ------------------------------------------------------------------
   // Derived sizes and terminal counts
   // ------------------------------------------------------------------
   localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int IW      = $clog2(NUM_DIG);

   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIG - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [2*NUM_DIG-1:0] active_q, active_d;
   logic [2*NUM_DIG-1:0] shadow_q, shadow_d;
   logic                 pending_q, pending_d;
   logic [1:0]           dig_q, dig_d;
   logic [NUM_DIG-1:0]   an_q, an_d;
   logic                 fs_q, fs_d;
   logic                 lit_q, lit_d;

   logic                 state_chg;
   logic                 enter_drive;
   logic                 frame_bnd;

`ifdef SEG7_BLINK_EN
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] FR_LAST = FW'(BLINK_FRAMES - 1);

   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          phase_q, phase_d;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: one IDLE cycle, then alternate DRIVE and BLANK slots
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = ST_DRIVE;
         ST_DRIVE: if (cnt_q == DWELL_LAST) state_d = ST_BLANK;
         ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_DRIVE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Transition decode, slot counter and digit index
   always_comb begin
      state_chg   = (state_d != state_q);
      enter_drive = state_chg && (state_d == ST_DRIVE);

      // The counter restarts on every state change, so it only ever counts
      // up to the length of the current state.
      cnt_d = state_chg ? '0 : cnt_q + CW'(1);

      idx_d = idx_q;
      if (state_q == ST_IDLE) begin
         idx_d = '0;
      end else if ((state_q == ST_BLANK) && enter_drive) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end

      // A frame boundary is any entry into DRIVE for digit 0. This includes
      // the first entry after IDLE.
      frame_bnd = enter_drive && (idx_d == '0);
   end

   // Double-buffered load path: shadow captures, boundary publishes
   always_comb begin
      shadow_d  = iLoad ? iVal : shadow_q;
      pending_d = pending_q;
      active_d  = active_q;
      if (frame_bnd) begin
         // A load that coincides with the boundary bypasses the shadow so
         // the new frame already shows it.
         pending_d = 1'b0;
         if (iLoad) begin
            active_d = iVal;
         end else if (pending_q) begin
            active_d = shadow_q;
         end
      end else if (iLoad) begin
         pending_d = 1'b1;
      end
   end

`ifdef SEG7_BLINK_EN
   // Blink phase: toggles after every BLINK_FRAMES completed frames
   always_comb begin
      fcnt_d  = fcnt_q;
      phase_d = phase_q;
      // Only a wrap from the last digit completes a frame. The first entry
      // after IDLE starts frame 0 and does not count.
      if (frame_bnd && (state_q == ST_BLANK)) begin
         if (fcnt_q == FR_LAST) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            fcnt_d = fcnt_q + FW'(1);
         end
      end
      lit_d = !(phase_d && iBlinkMask[idx_d]);
   end
`else
   // Every digit is lit in its own slot
   always_comb begin
      lit_d = 1'b1;
   end
`endif

   // FSM outputs: registered enables and code, updated when a state is entered
   always_comb begin
      an_d  = an_q;
      dig_d = dig_q;
      fs_d  = 1'b0;
      if (enter_drive) begin
         dig_d = active_d[{idx_d, 1'b0} +: 2];
         fs_d  = (idx_d == '0);
         for (int k = 0; k < NUM_DIG; k++) begin
            an_d[k] = !(lit_d && (idx_d == IW'(k)));
         end
      end else if (state_chg) begin
         an_d = '1;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         active_q  <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         dig_q     <= 2'b00;
         an_q      <= '1;
         fs_q      <= 1'b0;
         lit_q     <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         dig_q     <= dig_d;
         an_q      <= an_d;
         fs_q      <= fs_d;
         lit_q     <= lit_d;
      end
   end

`ifdef SEG7_BLINK_EN
   // Frame counter and blink phase registers
   always_ff @(posedge clk) begin
      if (reset) begin
         fcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         fcnt_q  <= fcnt_d;
         phase_q <= phase_d;
      end
   end
`endif

   // Segment gating: decoder output passes only while a lit digit is driven
   always_comb begin
      oSEG = ((state_q == ST_DRIVE) && lit_q) ? iSEG : 7'h7F;
   end

   assign oDIG        = dig_q;
   assign oAN         = an_q;
   assign oFrameStart = fs_q;
   assign oDbgState   = state_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl with NUM_DIG=4, DWELL_CYC=4 and BLANK_CYC=1,
// so one frame is 20 cycles. Expected per-cycle outputs are built from the
// slot pattern of each frame and queued. Every cycle pops one entry and
// compares it. The blink section is compiled when SEG7_BLINK_EN is defined.

module tb_seg7_scan_ctrl;

   localparam int NUM_DIG = 4;
   localparam int DWELL   = 4;
   localparam int BLANK   = 1;
   localparam int SLOT    = DWELL + BLANK;
   localparam int FRAME   = NUM_DIG * SLOT;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       reset;
   logic       iLoad;
   logic [7:0] iVal;
   logic [1:0] oDIG;
   logic [6:0] iSEG;
   logic [6:0] oSEG;
   logic [3:0] oAN;
   logic       oFrameStart;
   logic [1:0] oDbgState;
`ifdef SEG7_BLINK_EN
   logic [3:0] iBlinkMask;
`endif

   always #5 clk = ~clk;

   // Stand-in for the shared SEG7 decoder (active-low patterns for 0..3)
   function automatic logic [6:0] seg_lut(input logic [1:0] c);
      case (c)
         2'd0:    seg_lut = 7'h40;
         2'd1:    seg_lut = 7'h79;
         2'd2:    seg_lut = 7'h24;
         default: seg_lut = 7'h30;
      endcase
   endfunction

   assign iSEG = seg_lut(oDIG);

   seg7_scan_ctrl #(
      .NUM_DIG     (NUM_DIG),
      .DWELL_CYC   (DWELL),
      .BLANK_CYC   (BLANK)
`ifdef SEG7_BLINK_EN
      ,
      .BLINK_FRAMES(2)
`endif
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .iVal       (iVal),
      .iLoad      (iLoad),
      .oDIG       (oDIG),
      .iSEG       (iSEG),
      .oSEG       (oSEG),
      .oAN        (oAN),
      .oFrameStart(oFrameStart),
`ifdef SEG7_BLINK_EN
      .iBlinkMask (iBlinkMask),
`endif
      .oDbgState  (oDbgState)
   );

   // ---------------- scoreboard ----------------
   // Observation word: {oAN[3:0], oDIG[1:0], oFrameStart, oSEG[6:0]}
   localparam logic [13:0] RST_OBS = {4'b1111, 2'b00, 1'b0, 7'h7F};

   logic [13:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;

   function automatic logic [13:0] mk_obs(input logic [3:0] an, input logic [1:0] dig,
                                          input logic fs, input logic [6:0] seg);
      mk_obs = {an, dig, fs, seg};
   endfunction

   // Queue the expected outputs of the first n cycles of one frame. The frame
   // shows the digit codes in `codes`; digits set in `dark` stay unlit; a
   // synchronous reset applied at offset rst_at yields reset values there.
   task automatic push_frame(input logic [7:0] codes, input int n,
                             input logic [3:0] dark, input int rst_at);
      for (int off = 0; off < n; off++) begin
         int         d;
         int         pos;
         logic [1:0] code;
         logic [3:0] one;
         d    = off / SLOT;
         pos  = off % SLOT;
         code = codes[2*d +: 2];
         one  = 4'b0001 << d;
         if (off == rst_at) begin
            exp_q.push_back(RST_OBS);
         end else if (pos < DWELL) begin
            if (dark[d])
               exp_q.push_back(mk_obs(4'b1111, code, (d == 0) && (pos == 0), 7'h7F));
            else
               exp_q.push_back(mk_obs(~one, code, (d == 0) && (pos == 0), seg_lut(code)));
         end else begin
            exp_q.push_back(mk_obs(4'b1111, code, 1'b0, 7'h7F));
         end
      end
   endtask

   // ---------------- driver ----------------
   // Apply inputs for one cycle and compare after the rising edge.
   task automatic tick(input logic rst, input logic ld, input logic [7:0] val,
                       input string name);
      logic [13:0] got;
      logic [13:0] exp;
      reset = rst;
      iLoad = ld;
      iVal  = val;
      @(negedge clk);
      cyc++;
      got = {oAN, oDIG, oFrameStart, oSEG};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s cyc=%0d: expected queue empty, got an=%b dig=%0d", name, cyc,
                  oAN, oDIG);
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got an=%b dig=%0d fs=%b seg=%h, expected an=%b dig=%0d fs=%b seg=%h",
                     name, cyc, got[13:10], got[9:8], got[7], got[6:0],
                     exp[13:10], exp[9:8], exp[7], exp[6:0]);
         end
      end
   endtask

   // ---------------- stimulus table ----------------
   // One record per frame: cycles to run, codes the frame must show, up to
   // two loads at the given offsets (-1 = none) and an optional reset offset.
   typedef struct {
      int         n;
      logic [7:0] codes;
      int         ld_a;
      logic [7:0] va;
      int         ld_b;
      logic [7:0] vb;
      int         rst_at;
      string      name;
   } frame_vec_t;

   frame_vec_t vecs[11];

   initial begin
      reset = 1'b1;
      iLoad = 1'b0;
      iVal  = 8'h00;
`ifdef SEG7_BLINK_EN
      iBlinkMask = 4'b0000;
`endif

      vecs[0]  = '{FRAME, 8'h00, 7,  8'hE4, -1, 8'h00, -1, "first_frame_load_mid"};
      vecs[1]  = '{FRAME, 8'hE4, -1, 8'h00, -1, 8'h00, -1, "frame_e4_a"};
      vecs[2]  = '{FRAME, 8'hE4, -1, 8'h00, -1, 8'h00, -1, "frame_e4_b"};
      vecs[3]  = '{FRAME, 8'hE4, 11, 8'h00, -1, 8'h00, -1, "load_during_dig2"};
      vecs[4]  = '{FRAME, 8'h00, -1, 8'h00, -1, 8'h00, -1, "frame_after_load"};
      vecs[5]  = '{FRAME, 8'hFF, 0,  8'hFF, -1, 8'h00, -1, "load_at_boundary"};
      vecs[6]  = '{FRAME, 8'hFF, 3,  8'h1B, 12, 8'h6C, -1, "two_loads"};
      vecs[7]  = '{FRAME, 8'h6C, 19, 8'h5A, -1, 8'h00, -1, "last_load_wins"};
      vecs[8]  = '{13,    8'h5A, 5,  8'hC3, -1, 8'h00, 12, "reset_mid_dig2"};
      vecs[9]  = '{FRAME, 8'h00, -1, 8'h00, -1, 8'h00, -1, "restart_after_reset"};
      vecs[10] = '{FRAME, 8'h00, -1, 8'h00, -1, 8'h00, -1, "pending_lost"};

      // Reset held for 3 cycles; the last one is the IDLE cycle
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(RST_OBS);
         tick(1'b1, 1'b0, 8'h00, "reset_state");
      end

      // Table-driven frames
      for (int v = 0; v < 11; v++) begin
         push_frame(vecs[v].codes, vecs[v].n, 4'b0000, vecs[v].rst_at);
         for (int off = 0; off < vecs[v].n; off++) begin
            logic       r;
            logic       l;
            logic [7:0] val;
            r   = (off == vecs[v].rst_at);
            l   = (off == vecs[v].ld_a) || (off == vecs[v].ld_b);
            val = (off == vecs[v].ld_b) ? vecs[v].vb : vecs[v].va;
            tick(r, l, val, vecs[v].name);
         end
      end

`ifdef SEG7_BLINK_EN
      // Blink: digit 1 dark in frames 2 and 3, lit otherwise
      iBlinkMask = 4'b0010;
      exp_q.push_back(RST_OBS);
      tick(1'b1, 1'b0, 8'h00, "blink_reset");
      for (int f = 0; f < 6; f++) begin
         push_frame(8'h00, FRAME, ((f == 2) || (f == 3)) ? 4'b0010 : 4'b0000, -1);
         for (int off = 0; off < FRAME; off++) begin
            tick(1'b0, 1'b0, 8'h00, "blink_frame");
         end
      end
`endif

      // Every queued expectation must have been consumed
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expectations: got %0d entries left, expected 0",
                  exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
